// File: rtl/rps_pkg.sv
// rtl/rps_pkg.sv - shared rock-paper-scissors move constants, FSM states and helpers
//
// Purpose: common definitions for the computer player blocks.
//   ROCK/SCISSOR/PAPER : move encodings
//   state_t            : predictor FSM states
//   beat()             : move that defeats a given move
package rps_pkg;

   localparam int ROCK    = 0;
   localparam int SCISSOR = 1;
   localparam int PAPER   = 2;

   typedef enum logic [1:0] {
      INIT    = 2'd0,
      IDLE    = 2'd1,
      UPDATE  = 2'd2,
      PREDICT = 2'd3
   } state_t;

   // Each move is beaten by the move encoded just below it, with wrap.
   function automatic int beat(input int m, input int num_moves);
      return (m == 0) ? num_moves - 1 : m - 1;
   endfunction

endpackage

// File: rtl/markov_predictor_if.sv
// rtl/markov_predictor_if.sv - round/choice handshake between scoring logic and the predictor
//
// Purpose: groups the round strobe, both moves and the predictor responses.
//   master : scoring side, drives round_valid/user_move/com_move/mode
//   slave  : predictor side, drives ready/choice/choice_valid/err
interface markov_predictor_if #(
   parameter int MOVE_W = 2
);

   logic              round_valid;
   logic [MOVE_W-1:0] user_move;
   logic [MOVE_W-1:0] com_move;
   logic              mode;
   logic              ready;
   logic [MOVE_W-1:0] choice;
   logic              choice_valid;
   logic              err;

   modport master (
      output round_valid, user_move, com_move, mode,
      input  ready, choice, choice_valid, err
   );

   modport slave (
      input  round_valid, user_move, com_move, mode,
      output ready, choice, choice_valid, err
   );

endinterface

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - free-running 16-bit Galois LFSR (taps 16'hB400)
//
// Purpose: pseudo-random source shared by the random and Markov players.
//   clock      : system clock
//   reset_n    : asynchronous active-low reset, loads SEED
//   lfsr_state : current LFSR value, advances every clock
module lfsr16 #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clock,
   input  logic        reset_n,
   output logic [15:0] lfsr_state
);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         lfsr_state <= SEED;
      end else begin
         lfsr_state <= (lfsr_state >> 1) ^ (lfsr_state[0] ? 16'hB400 : 16'h0000);
      end
   end

endmodule

// File: rtl/markov_predictor.sv
// rtl/markov_predictor.sv - Markov-chain move predictor for the rock-paper-scissors computer player
//
// Purpose: counts user-move transitions per {com,user} history context and
// plays the move that beats the most likely next user move.
//   clock   : system clock
//   reset_n : asynchronous active-low reset
//   bus     : slave side of markov_predictor_if
//             in  round_valid, user_move, com_move, mode
//             out ready, choice, choice_valid, err
module markov_predictor
   import rps_pkg::*;
#(
   parameter int          NUM_MOVES = 3,
   parameter int          MOVE_W    = 2,
   parameter int          HIST      = 1,
   parameter int          CNT_W     = 8,
   parameter logic [15:0] SEED      = 16'hACE1
) (
   input logic               clock,
   input logic               reset_n,
   markov_predictor_if.slave bus
);

   localparam int CTX_W = 2 * MOVE_W * HIST;
   localparam int ROWS  = 1 << CTX_W;
   localparam int HF_W  = $clog2(HIST + 1);

   localparam logic [HF_W-1:0]  HF_FULL  = HF_W'(HIST);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CTX_W-1:0] LAST_ROW = '1;

   state_t            state;
   logic [CTX_W-1:0]  ctx;
   logic [CTX_W-1:0]  row_idx;
   logic [HF_W-1:0]   hfill;
   logic [MOVE_W-1:0] lat_user;
   logic [MOVE_W-1:0] lat_com;
   logic              lat_mode;
   logic [15:0]       lfsr;

   logic [CNT_W-1:0]  cnt_tbl [ROWS][NUM_MOVES];
   logic [CNT_W-1:0]  rd_row  [NUM_MOVES];
   logic [CNT_W-1:0]  max_val;
   int                rnd_idx;
   int                pred_idx;
   logic              use_rnd;
   logic              move_illegal;

   lfsr16 #(.SEED(SEED)) u_lfsr (
      .clock      (clock),
      .reset_n    (reset_n),
      .lfsr_state (lfsr)
   );

   always_comb rnd_idx = int'(lfsr) % NUM_MOVES;

   // Single row read port: UPDATE reads the old context, PREDICT reads the
   // freshly shifted one, both through ctx.
   always_comb begin
      for (int m = 0; m < NUM_MOVES; m++) begin
         rd_row[m] = cnt_tbl[ctx][m];
      end
   end

   // Maximum counter, ties broken by scanning upward from the random index.
   always_comb begin
      int   j;
      logic found;
      max_val  = '0;
      pred_idx = 0;
      found    = 1'b0;
      j        = 0;
      for (int m = 0; m < NUM_MOVES; m++) begin
         if (rd_row[m] > max_val) max_val = rd_row[m];
      end
      for (int i = 0; i < NUM_MOVES; i++) begin
         j = rnd_idx + i;
         if (j >= NUM_MOVES) j = j - NUM_MOVES;
         if (!found && rd_row[j] == max_val) begin
            pred_idx = j;
            found    = 1'b1;
         end
      end
   end

   always_comb use_rnd = !lat_mode || (hfill != HF_FULL) || (max_val == '0);

   always_comb move_illegal = (int'(bus.user_move) >= NUM_MOVES) ||
                              (int'(bus.com_move) >= NUM_MOVES);

   // Table storage carries no reset; INIT sweeps every row to zero instead.
   always_ff @(posedge clock) begin
      if (state == INIT) begin
         for (int m = 0; m < NUM_MOVES; m++) begin
            cnt_tbl[row_idx][m] <= '0;
         end
      end else if (state == UPDATE && hfill == HF_FULL) begin
         if (rd_row[lat_user] == CNT_MAX) begin
            // Halve the whole row to keep relative weights, then count.
            for (int m = 0; m < NUM_MOVES; m++) begin
               cnt_tbl[ctx][m] <= (rd_row[m] >> 1) +
                                  ((m == int'(lat_user)) ? CNT_W'(1) : CNT_W'(0));
            end
         end else begin
            cnt_tbl[ctx][lat_user] <= rd_row[lat_user] + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state            <= INIT;
         row_idx          <= '0;
         ctx              <= '0;
         hfill            <= '0;
         lat_user         <= '0;
         lat_com          <= '0;
         lat_mode         <= 1'b0;
         bus.ready        <= 1'b0;
         bus.choice       <= MOVE_W'(ROCK);
         bus.choice_valid <= 1'b0;
         bus.err          <= 1'b0;
      end else begin
         bus.choice_valid <= 1'b0;
         bus.err          <= 1'b0;
         case (state)
            INIT: begin
               row_idx <= row_idx + CTX_W'(1);
               if (row_idx == LAST_ROW) begin
                  state     <= IDLE;
                  bus.ready <= 1'b1;
               end
            end
            IDLE: begin
               if (bus.round_valid) begin
                  if (move_illegal) begin
                     bus.err <= 1'b1;
                  end else begin
                     lat_user  <= bus.user_move;
                     lat_com   <= bus.com_move;
                     lat_mode  <= bus.mode;
                     bus.ready <= 1'b0;
                     state     <= UPDATE;
                  end
               end
            end
            UPDATE: begin
               // Newest pair enters the LSBs; the oldest falls off the top.
               ctx <= CTX_W'({ctx, lat_com, lat_user});
               if (hfill != HF_FULL) hfill <= hfill + HF_W'(1);
               state <= PREDICT;
            end
            PREDICT: begin
               bus.choice       <= use_rnd ? MOVE_W'(rnd_idx) : MOVE_W'(beat(pred_idx, NUM_MOVES));
               bus.choice_valid <= 1'b1;
               bus.ready        <= 1'b1;
               state            <= IDLE;
            end
            default: state <= INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_markov_predictor.sv
// tb/tb_markov_predictor.sv - self-checking bench for markov_predictor (HIST=1 and HIST=2 side by side)
module tb_markov_predictor;
   import rps_pkg::*;

   localparam int          N    = 3;
   localparam logic [15:0] SEED = 16'hACE1;

   logic       clock       = 1'b0;
   logic       reset_n     = 1'b0;
   logic       round_valid = 1'b0;
   logic [1:0] user_move   = 2'd0;
   logic [1:0] com_move    = 2'd0;
   logic       mode        = 1'b0;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clock = ~clock;

   markov_predictor_if #(.MOVE_W(2)) bus1 ();
   markov_predictor_if #(.MOVE_W(2)) bus2 ();

   assign bus1.round_valid = round_valid;
   assign bus1.user_move   = user_move;
   assign bus1.com_move    = com_move;
   assign bus1.mode        = mode;
   assign bus2.round_valid = round_valid;
   assign bus2.user_move   = user_move;
   assign bus2.com_move    = com_move;
   assign bus2.mode        = mode;

   markov_predictor #(.HIST(1)) dut_h1 (.clock(clock), .reset_n(reset_n), .bus(bus1));
   markov_predictor #(.HIST(2)) dut_h2 (.clock(clock), .reset_n(reset_n), .bus(bus2));

   // ---------------- reference model ----------------
   logic [15:0] mlfsr;
   int tbl [2][256][N];
   int ctx [2];
   int hfill [2];
   int init_left [2];
   int busy [2];
   int pend [2];
   int exp_choice [2];
   bit exp_ready [2];
   bit exp_cv [2];
   bit exp_err [2];

   function automatic logic [15:0] lfsr_next(input logic [15:0] x);
      return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
   endfunction

   task automatic chk(input string name, input int act, input int exp_v);
      n_cmp++;
      if (act != exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp_v, $time);
      end
   endtask

   task automatic model_reset();
      mlfsr = SEED;
      for (int k = 0; k < 2; k++) begin
         init_left[k]  = 1 << (4 * (k + 1));
         busy[k]       = 0;
         ctx[k]        = 0;
         hfill[k]      = 0;
         pend[k]       = 0;
         exp_choice[k] = 0;
         exp_ready[k]  = 0;
         exp_cv[k]     = 0;
         exp_err[k]    = 0;
         for (int r = 0; r < 256; r++)
            for (int m = 0; m < N; m++) tbl[k][r][m] = 0;
      end
   endtask

   task automatic model_round(input int k, input int u, input int c, input int md, input int rnd);
      int h, rows, r, maxv, p, j;
      h    = k + 1;
      rows = 1 << (4 * h);
      if (hfill[k] == h) begin
         r = ctx[k];
         if (tbl[k][r][u] == 255)
            for (int m = 0; m < N; m++) tbl[k][r][m] = tbl[k][r][m] / 2;
         tbl[k][r][u] = tbl[k][r][u] + 1;
      end
      ctx[k] = (ctx[k] * 16 + c * 4 + u) % rows;
      if (hfill[k] < h) hfill[k] = hfill[k] + 1;
      maxv = 0;
      for (int m = 0; m < N; m++) if (tbl[k][ctx[k]][m] > maxv) maxv = tbl[k][ctx[k]][m];
      if (md == 0 || hfill[k] < h || maxv == 0) begin
         pend[k] = rnd;
      end else begin
         p = -1;
         for (int i = 0; i < N; i++) begin
            j = (rnd + i) % N;
            if (p < 0 && tbl[k][ctx[k]][j] == maxv) p = j;
         end
         pend[k] = (p == 0) ? N - 1 : p - 1;
      end
   endtask

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         model_reset();
      end else begin
         int rnd;
         // the prediction uses the LFSR value two cycles after acceptance
         rnd = int'(lfsr_next(lfsr_next(mlfsr))) % N;
         for (int k = 0; k < 2; k++) begin
            exp_cv[k]  = 0;
            exp_err[k] = 0;
            if (init_left[k] > 0) begin
               init_left[k] = init_left[k] - 1;
               if (init_left[k] == 0) exp_ready[k] = 1;
            end else if (busy[k] == 2) begin
               busy[k] = 1;
            end else if (busy[k] == 1) begin
               busy[k]       = 0;
               exp_ready[k]  = 1;
               exp_cv[k]     = 1;
               exp_choice[k] = pend[k];
            end else if (round_valid) begin
               if (int'(user_move) >= N || int'(com_move) >= N) begin
                  exp_err[k] = 1;
               end else begin
                  model_round(k, int'(user_move), int'(com_move), int'(mode), rnd);
                  busy[k]      = 2;
                  exp_ready[k] = 0;
               end
            end
         end
         mlfsr = lfsr_next(mlfsr);
      end
   end

   always @(negedge clock) begin
      chk("h1_ready",  int'(bus1.ready),        int'(exp_ready[0]));
      chk("h1_cv",     int'(bus1.choice_valid), int'(exp_cv[0]));
      chk("h1_err",    int'(bus1.err),          int'(exp_err[0]));
      chk("h1_choice", int'(bus1.choice),       exp_choice[0]);
      chk("h2_ready",  int'(bus2.ready),        int'(exp_ready[1]));
      chk("h2_cv",     int'(bus2.choice_valid), int'(exp_cv[1]));
      chk("h2_err",    int'(bus2.err),          int'(exp_err[1]));
      chk("h2_choice", int'(bus2.choice),       exp_choice[1]);
   end

   // ---------------- stimulus ----------------
   task automatic wait_ready(input int budget);
      int cnt;
      cnt = 0;
      @(negedge clock);
      while (!(bus1.ready && bus2.ready) && cnt < budget) begin
         @(negedge clock);
         cnt++;
      end
      chk("ready_wait", int'(bus1.ready && bus2.ready), 1);
   endtask

   task automatic do_round(input int u, input int c, input int md, input bit extra,
                           output int lat, output int pulses, output int err1, output int rdy1);
      wait_ready(400);
      round_valid = 1'b1;
      user_move   = 2'(u);
      com_move    = 2'(c);
      mode        = md[0];
      lat    = 0;
      pulses = 0;
      err1   = 0;
      rdy1   = 0;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clock);
         if (!(extra && i < 3)) round_valid = 1'b0;
         if (i == 1) begin
            err1 = int'(bus1.err);
            rdy1 = int'(bus1.ready);
         end
         if (bus1.choice_valid) begin
            pulses++;
            if (lat == 0) lat = i;
         end
      end
   endtask

   task automatic check_init();
      int cnt;
      chk("init_ready_low", int'(bus1.ready), 0);
      chk("init_choice", int'(bus1.choice), 0);
      cnt = 0;
      while (!bus1.ready && cnt < 40) begin
         @(negedge clock);
         cnt++;
      end
      chk("init_cycles", cnt, 16);
      for (int r = 0; r < 16; r++)
         for (int m = 0; m < N; m++) chk("init_row_zero", int'(dut_h1.cnt_tbl[r][m]), 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int lat, pulses, e1, r1, cvc;
      model_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clock);
      #2 reset_n = 1'b1;
      check_init();
      wait_ready(400);

      // rock/rock rounds in Markov mode
      for (int r = 1; r <= 12; r++) begin
         do_round(ROCK, ROCK, 1, 1'b0, lat, pulses, e1, r1);
         chk("rock_latency", lat, 3);
         chk("rock_pulses", pulses, 1);
         if (r >= 2) chk("rock_choice_h1", int'(bus1.choice), PAPER);
         if (r >= 3) chk("rock_choice_h2", int'(bus2.choice), PAPER);
         if (r == 2) begin
            chk("h1_upd_r2", int'(dut_h1.cnt_tbl[0][0]), 1);
            chk("h2_noupd_r2", int'(dut_h2.cnt_tbl[0][0]), 0);
         end
         if (r == 3) chk("h2_upd_r3", int'(dut_h2.cnt_tbl[0][0]), 1);
      end
      chk("h1_cnt_11", int'(dut_h1.cnt_tbl[0][0]), 11);

      // drive the rock counter to saturation
      for (int r = 0; r < 244; r++) do_round(ROCK, ROCK, 1, 1'b0, lat, pulses, e1, r1);
      chk("h1_cnt_255", int'(dut_h1.cnt_tbl[0][0]), 255);
      chk("h2_cnt_254", int'(dut_h2.cnt_tbl[0][0]), 254);
      do_round(ROCK, ROCK, 1, 1'b0, lat, pulses, e1, r1);
      chk("h1_halve_128", int'(dut_h1.cnt_tbl[0][0]), 128);
      chk("h2_cnt_255", int'(dut_h2.cnt_tbl[0][0]), 255);
      do_round(ROCK, ROCK, 1, 1'b0, lat, pulses, e1, r1);
      chk("h1_cnt_129", int'(dut_h1.cnt_tbl[0][0]), 129);
      chk("h2_halve_128", int'(dut_h2.cnt_tbl[0][0]), 128);
      chk("sat_choice", int'(bus1.choice), PAPER);

      // illegal moves
      do_round(3, ROCK, 1, 1'b0, lat, pulses, e1, r1);
      chk("illegal_user_err", e1, 1);
      chk("illegal_user_ready", r1, 1);
      chk("illegal_user_cv", pulses, 0);
      chk("illegal_user_tbl", int'(dut_h1.cnt_tbl[0][0]), 129);
      do_round(ROCK, 3, 0, 1'b0, lat, pulses, e1, r1);
      chk("illegal_com_err", e1, 1);
      chk("illegal_com_cv", pulses, 0);

      // strobes while busy are ignored
      do_round(SCISSOR, PAPER, 1, 1'b1, lat, pulses, e1, r1);
      chk("busy_strobe_pulses", pulses, 1);
      chk("busy_strobe_latency", lat, 3);

      // randomized rounds
      for (int r = 0; r < 150; r++) begin
         int u, c;
         u = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
         c = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
         repeat ($urandom_range(0, 3)) @(negedge clock);
         do_round(u, c, int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), lat, pulses, e1, r1);
      end

      // reset during PREDICT
      wait_ready(400);
      round_valid = 1'b1;
      user_move   = 2'(ROCK);
      com_move    = 2'(ROCK);
      mode        = 1'b1;
      @(negedge clock);
      round_valid = 1'b0;
      @(negedge clock);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_choice", int'(bus1.choice), 0);
      chk("rst_ready", int'(bus1.ready), 0);
      cvc = 0;
      repeat (3) begin
         @(negedge clock);
         if (bus1.choice_valid || bus2.choice_valid) cvc++;
      end
      #2 reset_n = 1'b1;
      check_init();
      chk("rst_no_cv", cvc, 0);
      wait_ready(400);

      // history fill after reset
      do_round(ROCK, ROCK, 1, 1'b0, lat, pulses, e1, r1);
      do_round(ROCK, ROCK, 1, 1'b0, lat, pulses, e1, r1);
      chk("post_rst_h1_r2", int'(dut_h1.cnt_tbl[0][0]), 1);
      chk("post_rst_h2_r2", int'(dut_h2.cnt_tbl[0][0]), 0);
      do_round(ROCK, ROCK, 1, 1'b0, lat, pulses, e1, r1);
      chk("post_rst_h2_r3", int'(dut_h2.cnt_tbl[0][0]), 1);
      chk("post_rst_choice_h2", int'(bus2.choice), PAPER);

      // whole-table comparison against the model
      for (int r = 0; r < 16; r++)
         for (int m = 0; m < N; m++) chk("tbl_h1", int'(dut_h1.cnt_tbl[r][m]), tbl[0][r][m]);
      for (int r = 0; r < 256; r++)
         for (int m = 0; m < N; m++) chk("tbl_h2", int'(dut_h2.cnt_tbl[r][m]), tbl[1][r][m]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
